// File: rtl/riscv_sim_monitor.sv
// Run monitor for the riscv cores. It watches the imem/dmem observation buses,
// decides PASS/FAIL/TIMEOUT/HANG and logs every store seen during the run
// into a small show-ahead FIFO. It only observes and drives nothing into the core.
module riscv_sim_monitor #(
   parameter int               XLEN           = 32,
   parameter logic [XLEN-1:0]  PASS_ADDR      = XLEN'(100),
   parameter logic [XLEN-1:0]  PASS_DATA      = XLEN'(25),
   parameter int               TIMEOUT_CYCLES = 200,
   parameter int               HANG_CYCLES    = 16,
   parameter int               LOG_DEPTH      = 8,
   parameter int               CNT_W          = 16
) (
   input  logic                             i_clk,
   input  logic                             i_rstn,
   input  logic                             i_en,
   input  logic [XLEN-1:0]                  i_imem_pc,
   input  logic [XLEN-1:0]                  i_dmem_addr,
   input  logic                             i_dmem_wr_en,
   input  logic [3:0]                       i_dmem_byte_sel,
   input  logic [XLEN-1:0]                  i_dmem_wr_data,
   input  logic                             i_log_rd_en,
   output logic [2:0]                       o_state,
   output logic                             o_done,
   output logic                             o_pass,
   output logic [CNT_W-1:0]                 o_cycle_cnt,
   output logic                             o_log_valid,
   output logic [4+2*XLEN-1:0]              o_log_data,
   output logic [$clog2(LOG_DEPTH+1)-1:0]   o_log_count,
   output logic                             o_log_overflow
);

   localparam int PTR_W   = $clog2(LOG_DEPTH);
   localparam int LCNT_W  = $clog2(LOG_DEPTH + 1);
   localparam int ENTRY_W = 4 + 2 * XLEN;
   localparam int HANG_W  = (HANG_CYCLES < 2) ? 1 : $clog2(HANG_CYCLES + 1);

   // Last cycle-count value before a timeout fires.
   localparam logic [CNT_W-1:0]  TIMEOUT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   // Number of consecutive equal-PC comparisons that declares a hang.
   localparam logic [HANG_W:0]   HANG_LAST    = (HANG_CYCLES > 0) ? (HANG_W + 1)'(HANG_CYCLES - 1) : '0;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_PASS    = 3'd2,
      ST_FAIL    = 3'd3,
      ST_TIMEOUT = 3'd4,
      ST_HANG    = 3'd5
   } state_t;

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    cycle_cnt_reg, cycle_cnt_next;
   logic [HANG_W-1:0]   hang_cnt_reg, hang_cnt_next;
   logic [XLEN-1:0]     prev_pc_reg, prev_pc_next;

   logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [LCNT_W-1:0]   log_count_reg;
   logic                log_overflow_reg;
   logic [ENTRY_W-1:0]  log_mem [LOG_DEPTH];

   logic                log_push;
   logic                log_pop;
   logic                log_full;
   logic                log_accept;
   logic                log_drop;
   logic                log_valid;
   logic [ENTRY_W-1:0]  log_head;

   logic                pc_same;
   logic [HANG_W:0]     hang_inc;
   logic                hang_trip;
   logic                timeout_hit;
   logic                pass_hit;

   // Run-condition decodes used by the next-state logic.
   always_comb begin
      pc_same     = (i_imem_pc == prev_pc_reg);
      hang_inc    = {1'b0, hang_cnt_reg} + 1'b1;
      hang_trip   = (HANG_CYCLES != 0) && pc_same && (hang_inc >= HANG_LAST);
      timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_cnt_reg == TIMEOUT_LAST);
      pass_hit    = i_dmem_wr_en && (i_dmem_addr == PASS_ADDR);
   end

   // Next-state, counter and PC-history logic; terminal states freeze everything.
   always_comb begin
      state_next     = state_reg;
      cycle_cnt_next = cycle_cnt_reg;
      hang_cnt_next  = hang_cnt_reg;
      prev_pc_next   = prev_pc_reg;
      log_push       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (i_en) state_next = ST_RUN;
         end
         ST_RUN: begin
            cycle_cnt_next = (cycle_cnt_reg == {CNT_W{1'b1}}) ? cycle_cnt_reg : cycle_cnt_reg + 1'b1;
            prev_pc_next   = i_imem_pc;
            if (pc_same)
               hang_cnt_next = (hang_cnt_reg == {HANG_W{1'b1}}) ? hang_cnt_reg : hang_cnt_reg + 1'b1;
            else
               hang_cnt_next = '0;
            log_push = i_dmem_wr_en;
            // A store to the pass address outranks a hang, which outranks a timeout.
            if (pass_hit)
               state_next = (i_dmem_wr_data == PASS_DATA) ? ST_PASS : ST_FAIL;
            else if (hang_trip)
               state_next = ST_HANG;
            else if (timeout_hit)
               state_next = ST_TIMEOUT;
         end
         ST_PASS, ST_FAIL, ST_TIMEOUT, ST_HANG: begin
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Monitor state registers.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_reg     <= ST_IDLE;
         cycle_cnt_reg <= '0;
         hang_cnt_reg  <= '0;
         prev_pc_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         cycle_cnt_reg <= cycle_cnt_next;
         hang_cnt_reg  <= hang_cnt_next;
         prev_pc_reg   <= prev_pc_next;
      end
   end

   // FIFO control: a full FIFO still takes a push when the head leaves on the same edge.
   always_comb begin
      log_valid  = (log_count_reg != '0);
      log_full   = (log_count_reg == LCNT_W'(LOG_DEPTH));
      log_pop    = i_log_rd_en && log_valid;
      log_accept = log_push && (!log_full || log_pop);
      log_drop   = log_push && log_full && !log_pop;
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         wr_ptr_reg       <= '0;
         rd_ptr_reg       <= '0;
         log_count_reg    <= '0;
         log_overflow_reg <= 1'b0;
      end else begin
         if (log_accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (log_pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (log_accept && !log_pop)
            log_count_reg <= log_count_reg + 1'b1;
         else if (!log_accept && log_pop)
            log_count_reg <= log_count_reg - 1'b1;
         if (log_drop) log_overflow_reg <= 1'b1;
      end
   end

   // Store-log storage; left unreset so it maps onto plain RAM.
   always_ff @(posedge i_clk) begin
      if (log_accept)
         log_mem[wr_ptr_reg] <= {i_dmem_byte_sel, i_dmem_addr, i_dmem_wr_data};
   end

   // Show-ahead head: read addressed by the registered read pointer only.
   assign log_head = log_mem[rd_ptr_reg];

   // Force the head to zero while the FIFO is empty.
   genvar gi;
   generate
      for (gi = 0; gi < ENTRY_W; gi++) begin : g_head_gate
         assign o_log_data[gi] = log_head[gi] & log_valid;
      end
   endgenerate

   assign o_state        = state_reg;
   assign o_done         = (state_reg == ST_PASS) || (state_reg == ST_FAIL) ||
                           (state_reg == ST_TIMEOUT) || (state_reg == ST_HANG);
   assign o_pass         = (state_reg == ST_PASS);
   assign o_cycle_cnt    = cycle_cnt_reg;
   assign o_log_valid    = log_valid;
   assign o_log_count    = log_count_reg;
   assign o_log_overflow = log_overflow_reg;

endmodule

// File: doc/riscv_sim_monitor.md
Name: riscv_sim_monitor

Overview:
- Synthesizable run monitor that attaches to the riscv top-level imem/dmem observation buses. It replaces open-loop fixed-cycle simulation with self-checking pass/fail/timeout/hang detection.
- It logs every data-memory store into a parametrised FIFO, so benches and FPGA debug logic can drain and compare store traffic.
- It sits beside riscv_pipeline_top (or the single-cycle top). It is purely an observer and drives nothing into the core.

Parameters:
- XLEN, 32, data/address width of observed buses.
- PASS_ADDR, 32'd100, store address that terminates the test.
- PASS_DATA, 32'd25, store data that signals pass at PASS_ADDR.
- TIMEOUT_CYCLES, 200, RUN cycles before TIMEOUT; 0 disables.
- HANG_CYCLES, 16, consecutive cycles of unchanged PC that flag HANG; 0 disables.
- LOG_DEPTH, 8, store-log FIFO entries (power of two, at least 2).
- CNT_W, 16, width of the cycle counter.

Ports:
- i_clk, input, 1, clock.
- i_rstn, input, 1, asynchronous active-low reset.
- i_en, input, 1, start monitoring (IDLE->RUN).
- i_imem_pc, input, XLEN, fetch PC from core.
- i_dmem_addr, input, XLEN, dmem store address.
- i_dmem_wr_en, input, 1, dmem write strobe.
- i_dmem_byte_sel, input, 4, dmem byte lanes.
- i_dmem_wr_data, input, XLEN, dmem store data.
- i_log_rd_en, input, 1, pop FIFO head.
- o_state, output, 3, 0=IDLE 1=RUN 2=PASS 3=FAIL 4=TIMEOUT 5=HANG.
- o_done, output, 1, state is terminal (2..5).
- o_pass, output, 1, state==PASS.
- o_cycle_cnt, output, CNT_W, RUN cycles elapsed.
- o_log_valid, output, 1, FIFO not empty.
- o_log_data, output, 4+2*XLEN, head entry {byte_sel, addr, data}; 0 when empty.
- o_log_count, output, clog2(LOG_DEPTH+1), occupancy.
- o_log_overflow, output, 1, sticky: a store was dropped because the FIFO was full.

Behaviour:
- Reset (i_rstn low, asynchronous): state IDLE, o_cycle_cnt 0, hang counter 0, previous-PC register 0, FIFO empty (pointers 0, o_log_count 0, o_log_valid 0, o_log_data 0), o_log_overflow 0, o_done 0, o_pass 0.
- A reset asserted mid-run aborts immediately to these values. The FIFO memory array itself is not reset.
- State machine transitions:
  - IDLE: go to RUN on the clock edge where i_en=1. Inputs are otherwise ignored.
  - RUN: evaluate every cycle, registered, taking effect on the next edge. Priority is as follows.
    - (a) i_dmem_wr_en and i_dmem_addr==PASS_ADDR: PASS if i_dmem_wr_data==PASS_DATA, else FAIL.
    - (b) HANG_CYCLES!=0 and the hang counter reaches HANG_CYCLES-1 while PC is still equal: HANG.
    - (c) TIMEOUT_CYCLES!=0 and o_cycle_cnt==TIMEOUT_CYCLES-1: TIMEOUT.
  - PASS/FAIL/TIMEOUT/HANG: hold until reset. i_en is ignored.
- Cycle counter:
  - Counts the edges taken while in RUN; its value is 0 on the first RUN cycle.
  - Saturates at 2^CNT_W-1.
  - Freezes on entry to a terminal state. The value seen in the terminal state equals the count at the terminating cycle plus 1.
- Hang detection:
  - The PC is registered every cycle in RUN.
  - The hang counter increments when i_imem_pc equals the registered PC, and clears to 0 otherwise.
  - Its first comparison is against the value held from IDLE.
- Store log:
  - In RUN, every cycle with i_dmem_wr_en=1 pushes {byte_sel, addr, data}. This includes the terminating PASS/FAIL store.
  - Stores in IDLE or terminal states are not logged.
  - Reads are show-ahead: o_log_data is the head whenever o_log_valid=1.
  - i_log_rd_en with o_log_valid=1 pops on that edge. i_log_rd_en while empty is ignored.
  - Push when full with no pop: the entry is dropped and o_log_overflow is set (sticky until reset).
  - Push and pop in the same cycle when full: both are performed, count is unchanged, no overflow.
  - Push and pop in the same cycle when empty: the pop is ignored and the push is accepted (count becomes 1).
  - Pointers wrap modulo LOG_DEPTH.
  - Popping continues in terminal states.
- Output decode: o_done and o_pass are combinational decodes of the state register. No other output has combinational paths from inputs.

Test Plan:
- Reset, i_en=1, PC increments by 4 each cycle. At RUN cycle 10, store addr=100 data=25 -> state=PASS next edge, o_pass=1, o_cycle_cnt=11, o_log_count=1, head={4'hF,100,25}.
- Same as above but data=7 -> state=FAIL, o_pass=0, o_done=1.
- TIMEOUT_CYCLES=20, PC toggling, no stores -> state=TIMEOUT after 20 RUN cycles, o_cycle_cnt=20. At cycle 19, a store to 100/25 in the same cycle -> PASS wins.
- HANG_CYCLES=16, PC held at 0x40 from RUN cycle 5 -> HANG entered with o_cycle_cnt=21. A PC change at cycle 18 restarts the count.
- LOG_DEPTH=8: push 9 stores to addr 0x0..0x20 without reads -> count=8, overflow=1, head addr=0x0. Then pop+push together when full -> count stays 8, overflow unchanged. Drain 8 -> valid=0, o_log_data=0.
- Assert i_rstn low mid-RUN with count=5 -> state=IDLE, o_log_count=0, o_cycle_cnt=0 immediately (before the next clock edge).
